// File: rtl/dec_pkg.sv
// Shared constants for the one-hot decoder family and the display drivers
// that sit behind it.
//   mode_e      : operating mode encoding (direct decode or auto-scan)
//   DEC_N       : default select width
//   DEC_COUNT   : default scan length
//   DEC_DWELL_W : default dwell input width
package dec_pkg;

  typedef enum logic {
    MODE_DIRECT = 1'b0,
    MODE_SCAN   = 1'b1
  } mode_e;

  localparam int unsigned DEC_N       = 3;
  localparam int unsigned DEC_COUNT   = 8;
  localparam int unsigned DEC_DWELL_W = 8;

endpackage

// File: rtl/dec_onehot.sv
// Combinational N-to-2**N one-hot decoder with enable (active-high lines).
//   en_i  : 0 forces all lines low
//   sel_i : index to decode
//   y_o   : one-hot result, bit sel_i set when enabled
module dec_onehot #(
  parameter int unsigned N = 3
) (
  input  logic              en_i,
  input  logic [N-1:0]      sel_i,
  output logic [2**N-1:0]   y_o
);

  always_comb begin
    y_o = '0;
    if (en_i) begin
      y_o[sel_i] = 1'b1;
    end
  end

endmodule

// File: rtl/dec_nto2n_scan.sv
// Registered N-to-2**N one-hot decoder with direct and auto-scan modes.
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   en         : output enable; 0 forces lines inactive and freezes state
//   mode       : 0 direct decode of sel, 1 scan through 0..COUNT-1
//   sel        : index (direct) or jump target (scan), qualified by sel_valid
//   sel_valid  : one-cycle qualifier for sel, no backpressure
//   dwell      : extra cycles each index is held while scanning
//   l          : one-hot lines, inverted when ACTIVE_LOW=1
//   idx        : current registered index
//   wrap       : one-cycle pulse when the scan wraps COUNT-1 -> 0
//   err        : one-cycle pulse when an accepted sel is >= COUNT
module dec_nto2n_scan
  import dec_pkg::*;
#(
  parameter int unsigned N          = DEC_N,
  parameter int unsigned COUNT      = DEC_COUNT,
  parameter int unsigned DWELL_W    = DEC_DWELL_W,
  parameter int unsigned ACTIVE_LOW = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               mode,
  input  logic [N-1:0]       sel,
  input  logic               sel_valid,
  input  logic [DWELL_W-1:0] dwell,
  output logic [2**N-1:0]    l,
  output logic [N-1:0]       idx,
  output logic               wrap,
  output logic               err
);

  localparam int unsigned   W       = 2**N;
  localparam logic [N:0]    COUNT_W = (N+1)'(COUNT);
  localparam logic [N-1:0]  LAST    = N'(COUNT - 1);
  localparam logic [W-1:0]  L_IDLE  = (ACTIVE_LOW != 0) ? '1 : '0;

  logic [N-1:0]       idx_q, idx_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic               show_q, show_d;
  mode_e              mode_q;
  logic               wrap_q, wrap_d;
  logic               err_q, err_d;
  logic [W-1:0]       l_q;

  logic               mode_chg;
  logic               is_scan;
  logic               sel_ok;
  logic [W-1:0]       dec_lines;

  assign is_scan  = (mode_e'(mode) == MODE_SCAN);
  assign mode_chg = (mode_e'(mode) != mode_q);
  assign sel_ok   = ({1'b0, sel} < COUNT_W);

  // show_q remembers whether idx is currently displayable: an out-of-range
  // sel blanks the lines while idx keeps its old value, and either a good
  // sel, a scan step or entering scan mode brings the lines back.
  always_comb begin
    idx_d  = idx_q;
    cnt_d  = cnt_q;
    show_d = show_q;
    wrap_d = 1'b0;
    err_d  = 1'b0;
    if (en) begin
      if (mode_chg) begin
        cnt_d = '0;
        if (is_scan) begin
          show_d = 1'b1;
        end
      end
      if (sel_valid) begin
        if (sel_ok) begin
          idx_d  = sel;
          show_d = 1'b1;
        end else begin
          show_d = 1'b0;
          err_d  = 1'b1;
        end
        if (is_scan) begin
          cnt_d = '0;
        end
      end else if (is_scan && !mode_chg) begin
        // >= rather than == so a dwell lowered below the running count
        // advances immediately and the counter can never overflow.
        if (cnt_q >= dwell) begin
          cnt_d  = '0;
          show_d = 1'b1;
          if (idx_q == LAST) begin
            idx_d  = '0;
            wrap_d = 1'b1;
          end else begin
            idx_d = idx_q + N'(1);
          end
        end else begin
          cnt_d = cnt_q + DWELL_W'(1);
        end
      end
    end
  end

  dec_onehot #(.N(N)) u_dec (
    .en_i  (en && show_d),
    .sel_i (idx_d),
    .y_o   (dec_lines)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      cnt_q  <= '0;
      show_q <= 1'b1;
      mode_q <= MODE_DIRECT;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
      l_q    <= L_IDLE;
    end else begin
      idx_q  <= idx_d;
      cnt_q  <= cnt_d;
      show_q <= show_d;
      mode_q <= mode_e'(mode);
      wrap_q <= wrap_d;
      err_q  <= err_d;
      l_q    <= (ACTIVE_LOW != 0) ? ~dec_lines : dec_lines;
    end
  end

  assign l    = l_q;
  assign idx  = idx_q;
  assign wrap = wrap_q;
  assign err  = err_q;

endmodule
